// File: rtl/symbol_histogram.sv
// symbol_histogram
// Per-symbol occurrence counter for one frame of the gray-level stream.
// A frame ends on an accepted gray_last or, if GAP_CYC > 0, after GAP_CYC
// idle cycles. The finished histogram is then held on cnt_bus/cnt_sat/
// cnt_total with cnt_valid high until the downstream stage takes it.
module symbol_histogram #(
    parameter int DATA_W    = 8,
    parameter int SYM_W     = 3,
    parameter int FIRST_SYM = 1,
    parameter int NUM_SYM   = 6,
    parameter int CNT_W     = 8,
    parameter int TOT_W     = 16,
    parameter int GAP_CYC   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          gray_data,
    input  logic                       gray_valid,
    input  logic                       gray_last,
    output logic                       gray_ready,
    output logic                       cnt_valid,
    input  logic                       cnt_ready,
    output logic [NUM_SYM*CNT_W-1:0]   cnt_bus,
    output logic [NUM_SYM-1:0]         cnt_sat,
    output logic [TOT_W-1:0]           cnt_total
);

    // Gap counter only needs to reach GAP_CYC-1 before the frame closes.
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TOT_W-1:0] TOT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    w_gap_next;
    logic                r_valid;
    logic [TOT_W-1:0]    r_total;
    logic                w_take;
    logic                w_handshake;
    logic                w_zero;
    logic [SYM_W-1:0]    w_sym;
    logic                w_unused_data;

    // Input is only stalled while a finished histogram is waiting.
    assign gray_ready  = (r_state != S_DONE);

    // A beat offered together with clear is dropped, never counted.
    assign w_take      = gray_valid & gray_ready & ~clear;
    assign w_handshake = r_valid & cnt_ready;
    assign w_zero      = clear | w_handshake;
    assign w_sym       = gray_data[SYM_W-1:0];

    // Upper data bits carry no symbol information.
    assign w_unused_data = |(gray_data >> SYM_W);

    assign cnt_valid = r_valid;
    assign cnt_total = r_total;

    // State and gap counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_next;
            r_gap   <= w_gap_next;
        end
    end

    // Next-state logic: frame start, end by gray_last or idle gap, release on handshake.
    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap;
        if (clear) begin
            w_state_next = S_IDLE;
            w_gap_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        w_gap_next   = '0;
                        w_state_next = gray_last ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_take) begin
                        w_gap_next = '0;
                        if (gray_last) begin
                            w_state_next = S_DONE;
                        end
                    end else if (GAP_CYC > 0) begin
                        if (r_gap == GAP_LAST) begin
                            w_state_next = S_DONE;
                            w_gap_next   = '0;
                        end else begin
                            w_gap_next = r_gap + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_handshake) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_gap_next   = '0;
                end
            endcase
        end
    end

    // cnt_valid is registered alongside the state so it is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= (w_state_next == S_DONE);
        end
    end

    // Total of all accepted beats, including out-of-range codes; saturates silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total <= '0;
        end else if (w_zero) begin
            r_total <= '0;
        end else if (w_take && (r_total != TOT_MAX)) begin
            r_total <= r_total + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SYM; gi++) begin : g_sym
            localparam logic [SYM_W-1:0] LP_CODE = SYM_W'(FIRST_SYM + gi);

            logic             w_hit;
            logic [CNT_W-1:0] r_cnt;
            logic             r_sat;

            assign w_hit = w_take && (w_sym == LP_CODE);

            // Per-symbol counter: holds at full scale and latches a sticky overflow flag.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_sat <= 1'b0;
                end else if (w_zero) begin
                    r_cnt <= '0;
                    r_sat <= 1'b0;
                end else if (w_hit) begin
                    if (r_cnt == CNT_MAX) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign cnt_bus[gi*CNT_W +: CNT_W] = r_cnt;
            assign cnt_sat[gi]                = r_sat;
        end
    endgenerate

endmodule

// File: tb/tb_symbol_histogram.sv
// Bench for symbol_histogram: three instances (legacy gap=1, gray_last-only
// with 4-bit counters, gap=3 with 8 symbols from code 0) driven by directed
// and randomized frames, checked against a per-code hit-count model.
module tb_symbol_histogram;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  clr, vld, lst, crdy, grdy, cval;
    logic [7:0]  dat [3];
    logic [47:0] bus0;
    logic [5:0]  sat0;
    logic [15:0] tot0;
    logic [23:0] bus1;
    logic [5:0]  sat1;
    logic [15:0] tot1;
    logic [63:0] bus2;
    logic [7:0]  sat2;
    logic [15:0] tot2;

    symbol_histogram u0 (
        .clk(clk), .reset(reset), .clear(clr[0]),
        .gray_data(dat[0]), .gray_valid(vld[0]), .gray_last(lst[0]),
        .gray_ready(grdy[0]), .cnt_valid(cval[0]), .cnt_ready(crdy[0]),
        .cnt_bus(bus0), .cnt_sat(sat0), .cnt_total(tot0)
    );

    symbol_histogram #(.CNT_W(4), .GAP_CYC(0)) u1 (
        .clk(clk), .reset(reset), .clear(clr[1]),
        .gray_data(dat[1]), .gray_valid(vld[1]), .gray_last(lst[1]),
        .gray_ready(grdy[1]), .cnt_valid(cval[1]), .cnt_ready(crdy[1]),
        .cnt_bus(bus1), .cnt_sat(sat1), .cnt_total(tot1)
    );

    symbol_histogram #(.FIRST_SYM(0), .NUM_SYM(8), .GAP_CYC(3)) u2 (
        .clk(clk), .reset(reset), .clear(clr[2]),
        .gray_data(dat[2]), .gray_valid(vld[2]), .gray_last(lst[2]),
        .gray_ready(grdy[2]), .cnt_valid(cval[2]), .cnt_ready(crdy[2]),
        .cnt_bus(bus2), .cnt_sat(sat2), .cnt_total(tot2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raw hits per 3-bit code and total accepted beats in the current frame.
    int hits [8];
    int beats;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 8; i++) hits[i] = 0;
        beats = 0;
    endtask

    function automatic int first_of(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic int num_of(input int k);
        return (k == 2) ? 8 : 6;
    endfunction

    function automatic int cw_of(input int k);
        return (k == 1) ? 4 : 8;
    endfunction

    function automatic logic [63:0] exp_bus(input int k);
        logic [63:0] b;
        int mx;
        b  = '0;
        mx = (1 << cw_of(k)) - 1;
        for (int i = 0; i < num_of(k); i++) begin
            int v;
            v = (hits[first_of(k) + i] > mx) ? mx : hits[first_of(k) + i];
            b = b | (64'(v) << (i * cw_of(k)));
        end
        return b;
    endfunction

    function automatic logic [63:0] exp_sat(input int k);
        logic [63:0] s;
        int mx;
        s  = '0;
        mx = (1 << cw_of(k)) - 1;
        for (int i = 0; i < num_of(k); i++) begin
            s[i] = (hits[first_of(k) + i] > mx);
        end
        return s;
    endfunction

    function automatic logic [63:0] exp_tot();
        return 64'((beats > 65535) ? 65535 : beats);
    endfunction

    function automatic logic [63:0] obs_bus(input int k);
        case (k)
            0:       return 64'(bus0);
            1:       return 64'(bus1);
            default: return bus2;
        endcase
    endfunction

    function automatic logic [63:0] obs_sat(input int k);
        case (k)
            0:       return 64'(sat0);
            1:       return 64'(sat1);
            default: return 64'(sat2);
        endcase
    endfunction

    function automatic logic [63:0] obs_tot(input int k);
        case (k)
            0:       return 64'(tot0);
            1:       return 64'(tot1);
            default: return 64'(tot2);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat to instance k for exactly one edge and record it in the model.
    task automatic beat(input int k, input int code, input bit last);
        vld[k] = 1'b1;
        lst[k] = last;
        dat[k] = {5'($urandom), 3'(code)};
        hits[code]++;
        beats++;
        tick();
        vld[k] = 1'b0;
        lst[k] = 1'b0;
    endtask

    task automatic check_frame(input int k, input string tag);
        chk({tag, ".valid"}, 64'(cval[k]), 64'd1);
        chk({tag, ".ready"}, 64'(grdy[k]), 64'd0);
        chk({tag, ".bus"},   obs_bus(k),  exp_bus(k));
        chk({tag, ".sat"},   obs_sat(k),  exp_sat(k));
        chk({tag, ".total"}, obs_tot(k),  exp_tot());
        $display("frame %s inst=%0d beats=%0d total=%0d bus=0x%0h", tag, k, beats, obs_tot(k), obs_bus(k));
    endtask

    task automatic zero_check(input int k, input string tag);
        chk({tag, ".valid"}, 64'(cval[k]), 64'd0);
        chk({tag, ".ready"}, 64'(grdy[k]), 64'd1);
        chk({tag, ".bus"},   obs_bus(k),  64'd0);
        chk({tag, ".sat"},   obs_sat(k),  64'd0);
        chk({tag, ".total"}, obs_tot(k),  64'd0);
    endtask

    task automatic handshake(input int k, input string tag);
        crdy[k] = 1'b1;
        tick();
        crdy[k] = 1'b0;
        mreset();
        zero_check(k, tag);
    endtask

    int legacy [9] = '{1, 2, 2, 3, 6, 6, 6, 0, 7};

    initial begin
        reset = 1'b1;
        clr = '0; vld = '0; lst = '0; crdy = '0;
        for (int k = 0; k < 3; k++) dat[k] = '0;
        mreset();
        tick();
        tick();
        for (int k = 0; k < 3; k++) zero_check(k, "reset");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Legacy frame: back-to-back beats, the first idle edge ends it.
        crdy[0] = 1'b1;
        foreach (legacy[i]) beat(0, legacy[i], 1'b0);
        chk("legacy.pre", 64'(cval[0]), 64'd0);
        tick();
        check_frame(0, "legacy");
        tick();
        mreset();
        zero_check(0, "legacy.hs");
        tick();
        chk("legacy.pulse", 64'(cval[0]), 64'd0);
        crdy[0] = 1'b0;

        // gray_last only: idle cycles do not close the frame, then backpressure.
        beat(1, 4, 1'b0);
        beat(1, 4, 1'b0);
        repeat (5) tick();
        chk("nogap.valid", 64'(cval[1]), 64'd0);
        beat(1, 4, 1'b0);
        beat(1, 4, 1'b0);
        beat(1, 4, 1'b1);
        check_frame(1, "bp");
        for (int i = 0; i < 10; i++) begin
            vld[1] = 1'b1;
            lst[1] = 1'($urandom);
            dat[1] = 8'($urandom);
            tick();
            chk("stall.valid", 64'(cval[1]), 64'd1);
            chk("stall.ready", 64'(grdy[1]), 64'd0);
            chk("stall.bus",   obs_bus(1),  exp_bus(1));
        end
        vld[1] = 1'b0;
        lst[1] = 1'b0;
        handshake(1, "bp.hs");

        // Saturation with 4-bit counters.
        for (int i = 0; i < 20; i++) beat(1, 1, 1'b0);
        beat(1, 1, 1'b1);
        check_frame(1, "sat");
        chk("sat.flag", obs_sat(1), 64'b000001);
        handshake(1, "sat.hs");

        // Gap timeout at 3: beats at cycles 0, 2, 5.
        beat(2, int'($urandom_range(0, 7)), 1'b0);
        tick();
        chk("gap.c1", 64'(cval[2]), 64'd0);
        beat(2, int'($urandom_range(0, 7)), 1'b0);
        tick();
        tick();
        chk("gap.c4", 64'(cval[2]), 64'd0);
        beat(2, int'($urandom_range(0, 7)), 1'b0);
        tick();
        tick();
        chk("gap.n2", 64'(cval[2]), 64'd0);
        tick();
        check_frame(2, "gap");
        handshake(2, "gap.hs");

        // Eight symbols starting at code 0.
        for (int c = 0; c < 8; c++) beat(2, c, c == 7);
        check_frame(2, "reparam");
        handshake(2, "reparam.hs");

        // Clear mid-frame together with a valid beat.
        for (int i = 0; i < 4; i++) beat(0, int'($urandom_range(0, 7)), 1'b0);
        clr[0] = 1'b1;
        vld[0] = 1'b1;
        dat[0] = 8'($urandom);
        tick();
        clr[0] = 1'b0;
        vld[0] = 1'b0;
        mreset();
        zero_check(0, "clear");
        beat(0, 2, 1'b0);
        beat(0, 5, 1'b1);
        check_frame(0, "postclr");
        handshake(0, "postclr.hs");

        // Clear while a histogram is waiting.
        beat(0, 3, 1'b1);
        check_frame(0, "preclr");
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        mreset();
        zero_check(0, "clrdone");

        // Asynchronous reset between clock edges, mid-frame and while waiting.
        beat(0, 3, 1'b0);
        beat(0, 3, 1'b0);
        beat(0, 3, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        mreset();
        zero_check(0, "areset.acc");
        @(negedge clk);
        reset = 1'b0;
        tick();
        beat(0, 6, 1'b1);
        check_frame(0, "predone");
        #3;
        reset = 1'b1;
        #1;
        mreset();
        zero_check(0, "areset.done");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Random gray_last frames with idle gaps and delayed consumption.
        for (int f = 0; f < 6; f++) begin
            int len;
            len = int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                beat(1, int'($urandom_range(0, 7)), i == len - 1);
            end
            check_frame(1, "rnd1");
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rnd1.hold", 64'(cval[1]), 64'd1);
            end
            handshake(1, "rnd1.hs");
        end

        // Random gap-terminated frames with gaps shorter than the timeout.
        for (int f = 0; f < 5; f++) begin
            int len;
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) begin
                if (i != 0) repeat ($urandom_range(0, 2)) tick();
                beat(2, int'($urandom_range(0, 7)), 1'b0);
            end
            tick();
            tick();
            chk("rnd2.early", 64'(cval[2]), 64'd0);
            tick();
            check_frame(2, "rnd2");
            handshake(2, "rnd2.hs");
        end

        // Random legacy frames: back-to-back, ended by the first idle edge.
        for (int f = 0; f < 5; f++) begin
            int len;
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) beat(0, int'($urandom_range(0, 7)), 1'b0);
            tick();
            check_frame(0, "rnd0");
            handshake(0, "rnd0.hs");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/symbol_histogram.md
# symbol_histogram

Parametrised symbol-frequency counter for the Huffman coding pipeline. It accumulates per-symbol occurrence counts from the gray-level input stream over one frame, then presents the completed histogram to the downstream sort/merge stage through a valid/ready handshake. Compared with the fixed 6-symbol counter, it adds a configurable symbol range and widths, explicit or gap-based end of frame, saturation, a total-beat count, backpressure, and a synchronous clear.

## Interface
- DATA_W, 8: width of `gray_data`.
- SYM_W, 3: low bits of `gray_data` used as the symbol code; SYM_W <= DATA_W.
- FIRST_SYM, 1: lowest counted symbol code.
- NUM_SYM, 6: number of counted symbols, codes FIRST_SYM .. FIRST_SYM+NUM_SYM-1; must be <= 2^SYM_W - FIRST_SYM.
- CNT_W, 8: width of each symbol counter.
- TOT_W, 16: width of the total-beat counter.
- GAP_CYC, 1: idle cycles after the first beat that end a frame; 0 disables gap detection, leaving `gray_last` as the only terminator.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous abort and zero; highest priority after reset.
- gray_data  in  DATA_W  input sample.
- gray_valid  in  1  sample valid.
- gray_last  in  1  last sample of frame; qualified by `gray_valid & gray_ready`.
- gray_ready  out  1  block accepts samples.
- cnt_valid  out  1  histogram available.
- cnt_ready  in  1  downstream consumes histogram.
- cnt_bus  out  NUM_SYM*CNT_W  counts; symbol FIRST_SYM+i occupies bits [i*CNT_W +: CNT_W].
- cnt_sat  out  NUM_SYM  sticky per-symbol saturation flag.
- cnt_total  out  TOT_W  all accepted beats, including out-of-range codes; saturating.

## Operation
- States: IDLE, ACC, DONE. Reset puts the block in IDLE with all counters, `cnt_sat`, `cnt_total` and the gap counter at 0, `cnt_valid` = 0 and `gray_ready` = 1.
- A beat is accepted when `gray_valid & gray_ready`.
- `gray_ready` = 1 in IDLE and ACC, 0 in DONE.
- Symbol handling: sym = gray_data[SYM_W-1:0].
  - If sym is in range, counter[sym-FIRST_SYM] increments.
  - Out-of-range codes increment only `cnt_total`.
  - Upper data bits are ignored.
- Saturation: a counter at 2^CNT_W-1 holds its value, and its `cnt_sat` bit is set. The bit stays set until the frame is cleared. `cnt_total` saturates at 2^TOT_W-1 with no flag.
- IDLE -> ACC on an accepted beat without `gray_last`. IDLE -> DONE on an accepted beat with `gray_last`, giving a 1-beat frame.
- ACC:
  - Each cycle without an accepted beat increments the gap counter; an accepted beat resets it to 0.
  - Accepted beat with `gray_last` -> DONE.
  - Gap counter reaching GAP_CYC, with GAP_CYC > 0 -> DONE.
- DONE:
  - `cnt_valid` = 1; `cnt_bus`, `cnt_sat` and `cnt_total` are frozen and stable.
  - Input is stalled.
  - On `cnt_valid & cnt_ready`: all counters, flags and the total clear to 0, and the state goes to IDLE.
- `clear`: next edge zeroes all counters, flags and the total, goes to IDLE, and drops `cnt_valid`. Any beat presented in the same cycle is discarded. This applies in every state.
- With GAP_CYC = 1 and no `gray_last`, the block reproduces the legacy behaviour: the frame ends on the first idle cycle.

## Timing
- Counter, `cnt_total` and `cnt_sat` updates are visible the cycle after the accepting edge.
- `gray_last` accepted at edge N: `cnt_valid` = 1 after edge N, and the counts already include that beat. Latency is 1 cycle.
- Gap end: the last beat is accepted at edge N, with no further beats. The gap counter reaches GAP_CYC at edge N+GAP_CYC, so `cnt_valid` rises after edge N+GAP_CYC.
- `cnt_valid` holds until the handshake completes.
  - Handshake at edge M: `cnt_valid` = 0, counts = 0, `gray_ready` = 1 after M.
  - A new beat can be accepted at edge M+1.
- `cnt_ready` is ignored when `cnt_valid` = 0. `gray_last` is ignored unless the beat is accepted.
- Reset mid-frame: immediate, asynchronous return to the reset values; the partial frame is lost.
- All outputs are registered except `gray_ready`, which is decoded from state.

## Test plan
- **Legacy frame:** defaults, GAP_CYC = 1. Stream codes 1,2,2,3,6,6,6,0,7 back-to-back, then drop `gray_valid`, with `cnt_ready` = 1.
  - Expect a single `cnt_valid` pulse 1 cycle after the idle edge.
  - Expect counts {1,2,1,0,0,3} and `cnt_total` = 9.
  - Expect `gray_ready` back to 1 the next cycle.
- **`gray_last` with backpressure:** GAP_CYC = 0. Send 5 beats of code 4 with `gray_last` on the 5th; hold `cnt_ready` = 0 for 10 cycles.
  - Expect `cnt_valid` high for all 10 cycles, CNT4 = 5, and `gray_ready` = 0.
  - Beats offered during the stall must not be counted.
  - After `cnt_ready`, all counts are 0.
- **Saturation:** CNT_W = 4. Send 20 beats of code 1, then `gray_last`.
  - Expect CNT1 = 15, `cnt_sat` = 6'b000001 and `cnt_total` = 21.
- **Gap timeout:** GAP_CYC = 3. Beats at cycles 0, 2 and 5 (gaps of 1 and 2 cycles), then idle.
  - Expect a single frame of 3 beats.
  - Expect `cnt_valid` after the 3rd idle edge following cycle 5.
- **Clear/reset mid-frame:** after 4 beats, assert `clear` together with a valid beat.
  - Expect all counts = 0, IDLE, and the simultaneous beat not counted.
  - Repeat with async `reset` asserted mid-cycle: outputs must zero without waiting for a clock edge.
- **Reparametrised:** FIRST_SYM = 0, NUM_SYM = 8, SYM_W = 3. Send codes 0..7 once each, then `gray_last`.
  - Expect every count = 1 at the correct `cnt_bus` slice and `cnt_total` = 8.
